// File: rtl/calendar_pkg.sv
// Shared constants and date helpers for the Gregorian calendar block.
package calendar_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    typedef enum logic [2:0] {SUN, MON, TUE, WED, THU, FRI, SAT} dow_e;

    typedef enum logic {BCD_CONV, BCD_SHOW} bcd_state_e;

    localparam logic [4:0] RST_DAY   = 5'd1;
    localparam logic [3:0] RST_MONTH = JAN;
    localparam logic [2:0] RST_DOW   = 3'(SAT);

    function automatic logic month_ok(input logic [3:0] m);
        return (m >= JAN) && (m <= DEC);
    endfunction

    function automatic logic is_leap(input logic [13:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        logic [4:0] d;
        case (m)
            APR, JUN, SEP, NOV: d = 5'd30;
            FEB:                d = leap ? 5'd29 : 5'd28;
            default:            d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
module bin2bcd_seq #(
    parameter int IN_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  shreg;
    logic [15:0]      acc;
    logic [15:0]      acc_adj;
    logic [CNT_W-1:0] cnt;

    function automatic logic [15:0] dabble(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

    assign acc_adj = dabble(acc);
    assign bcd     = acc;

    always_ff @(posedge clk) begin
        if (start) begin
            shreg <= bin;
            acc   <= '0;
        end else if (busy) begin
            acc   <= {acc_adj[14:0], shreg[IN_W-1]};
            shreg <= shreg << 1;
        end
    end

    // start outranks reset so the owner can launch a conversion from its reset edge
    always_ff @(posedge clk) begin
        if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= CNT_W'(IN_W);
        end else if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/calendar_gregorian.sv
// Gregorian day/month/year calendar with validated loads and BCD display digits.
// Optional day-of-week counter is built when CALENDAR_DOW_EN is defined.
module calendar_gregorian
    import calendar_pkg::*;
#(
    parameter int YEARRES  = 12,
    parameter int RST_YEAR = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               day_tick,
    input  logic               load,
    input  logic [YEARRES+8:0] date_in,
    input  logic [2:0]         dow_in,
    output logic               load_err,
    output logic [4:0]         day,
    output logic [3:0]         month,
    output logic [YEARRES-1:0] year,
    output logic [2:0]         dow,
    output logic               new_month,
    output logic               new_year,
    output logic [3:0]         day_1s,
    output logic [3:0]         day_10s,
    output logic [3:0]         month_1s,
    output logic [3:0]         month_10s,
    output logic [3:0]         year_1s,
    output logic [3:0]         year_10s,
    output logic [3:0]         year_100s,
    output logic [3:0]         year_1000s,
    output logic               bcd_valid,
    output logic               bcd_ovf
);

    localparam logic [YEARRES-1:0] RST_YEAR_V = YEARRES'(RST_YEAR);

    function automatic logic year_over(input logic [YEARRES-1:0] y);
        return 14'(y) > 14'd9999;
    endfunction

    logic [4:0]         day_in;
    logic [3:0]         month_in;
    logic [YEARRES-1:0] year_in;
    logic [4:0]         dim_cur;
    logic [4:0]         dim_in;
    logic               load_ok;

    logic [4:0]         day_d;
    logic [3:0]         month_d;
    logic [YEARRES-1:0] year_d;
    logic               load_err_d;
    logic               new_month_d;
    logic               new_year_d;

    assign day_in   = date_in[YEARRES+8 -: 5];
    assign month_in = date_in[YEARRES+3 -: 4];
    assign year_in  = date_in[YEARRES-1:0];

    assign dim_cur = days_in_month(month, is_leap(14'(year)));
    assign dim_in  = days_in_month(month_in, is_leap(14'(year_in)));
    assign load_ok = month_ok(month_in) && (day_in != 5'd0) && (day_in <= dim_in);

    always_comb begin
        day_d       = day;
        month_d     = month;
        year_d      = year;
        load_err_d  = 1'b0;
        new_month_d = 1'b0;
        new_year_d  = 1'b0;
        if (load) begin
            if (load_ok) begin
                day_d   = day_in;
                month_d = month_in;
                year_d  = year_in;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (day_tick) begin
            if (!month_ok(month)) begin
                // corrupted month: resynchronise quietly to the 1st of January
                day_d   = 5'd1;
                month_d = JAN;
            end else if (day < dim_cur) begin
                day_d = day + 5'd1;
            end else begin
                day_d       = 5'd1;
                new_month_d = 1'b1;
                if (month == DEC) begin
                    month_d    = JAN;
                    year_d     = year + YEARRES'(1);
                    new_year_d = 1'b1;
                end else begin
                    month_d = month + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day       <= RST_DAY;
            month     <= RST_MONTH;
            year      <= RST_YEAR_V;
            load_err  <= 1'b0;
            new_month <= 1'b0;
            new_year  <= 1'b0;
            bcd_ovf   <= year_over(RST_YEAR_V);
        end else begin
            day       <= day_d;
            month     <= month_d;
            year      <= year_d;
            load_err  <= load_err_d;
            new_month <= new_month_d;
            new_year  <= new_year_d;
            bcd_ovf   <= year_over(year_d);
        end
    end

`ifdef CALENDAR_DOW_EN
    logic [2:0] dow_d;

    always_comb begin
        dow_d = dow;
        if (load) begin
            if (load_ok) dow_d = dow_in;
        end else if (day_tick) begin
            dow_d = (dow == 3'(SAT)) ? 3'(SUN) : dow + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dow <= RST_DOW;
        else        dow <= dow_d;
    end
`else
    logic unused_dow_in;

    assign dow           = 3'd0;
    assign unused_dow_in = ^dow_in;
`endif

    // Conversion launch: the reset edge and every date change feed the next date in
    logic               conv_start;
    logic [YEARRES-1:0] conv_day;
    logic [YEARRES-1:0] conv_month;
    logic [YEARRES-1:0] conv_year;
    logic               day_busy, month_busy, year_busy;
    logic               day_done, month_done, year_done;
    logic [15:0]        day_bcd, month_bcd, year_bcd;
    logic               unused_conv;

    assign conv_start = !rst_n || (day_d != day) || (month_d != month) || (year_d != year);
    assign conv_day   = rst_n ? YEARRES'(day_d)   : YEARRES'(RST_DAY);
    assign conv_month = rst_n ? YEARRES'(month_d) : YEARRES'(RST_MONTH);
    assign conv_year  = rst_n ? year_d            : RST_YEAR_V;

    bin2bcd_seq #(.IN_W(YEARRES)) u_bcd_day (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_day),
        .busy  (day_busy),
        .done  (day_done),
        .bcd   (day_bcd)
    );

    bin2bcd_seq #(.IN_W(YEARRES)) u_bcd_month (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_month),
        .busy  (month_busy),
        .done  (month_done),
        .bcd   (month_bcd)
    );

    bin2bcd_seq #(.IN_W(YEARRES)) u_bcd_year (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_year),
        .busy  (year_busy),
        .done  (year_done),
        .bcd   (year_bcd)
    );

    assign unused_conv = ^{day_busy, month_busy, year_busy, day_done, month_done,
                           day_bcd[15:8], month_bcd[15:8]};

    // All three converters run in lockstep, so the year instance paces the controller
    bcd_state_e bcd_state, bcd_state_d;

    always_comb begin
        bcd_state_d = bcd_state;
        if (conv_start)
            bcd_state_d = BCD_CONV;
        else if ((bcd_state == BCD_CONV) && year_done)
            bcd_state_d = BCD_SHOW;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bcd_state <= BCD_CONV;
        else        bcd_state <= bcd_state_d;
    end

    assign bcd_valid = (bcd_state == BCD_SHOW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            day_1s     <= 4'd0;
            day_10s    <= 4'd0;
            month_1s   <= 4'd0;
            month_10s  <= 4'd0;
            year_1s    <= 4'd0;
            year_10s   <= 4'd0;
            year_100s  <= 4'd0;
            year_1000s <= 4'd0;
        end else if ((bcd_state == BCD_CONV) && year_done && !conv_start) begin
            day_1s    <= day_bcd[3:0];
            day_10s   <= day_bcd[7:4];
            month_1s  <= month_bcd[3:0];
            month_10s <= month_bcd[7:4];
            if (year_over(year)) begin
                year_1s    <= 4'd9;
                year_10s   <= 4'd9;
                year_100s  <= 4'd9;
                year_1000s <= 4'd9;
            end else begin
                year_1s    <= year_bcd[3:0];
                year_10s   <= year_bcd[7:4];
                year_100s  <= year_bcd[11:8];
                year_1000s <= year_bcd[15:12];
            end
        end
    end

endmodule

// File: tb/tb_calendar_gregorian.sv
// Directed-vector bench for calendar_gregorian built with a 14-bit year.
module tb_calendar_gregorian;

    localparam int W = 14;
`ifdef CALENDAR_DOW_EN
    localparam bit DOW_EN = 1'b1;
`else
    localparam bit DOW_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         day_tick;
    logic         load;
    logic [W+8:0] date_in;
    logic [2:0]   dow_in;
    logic         load_err;
    logic [4:0]   day;
    logic [3:0]   month;
    logic [W-1:0] year;
    logic [2:0]   dow;
    logic         new_month, new_year;
    logic [3:0]   day_1s, day_10s, month_1s, month_10s;
    logic [3:0]   year_1s, year_10s, year_100s, year_1000s;
    logic         bcd_valid, bcd_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calendar_gregorian #(.YEARRES(W), .RST_YEAR(2000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (day_tick),
        .load       (load),
        .date_in    (date_in),
        .dow_in     (dow_in),
        .load_err   (load_err),
        .day        (day),
        .month      (month),
        .year       (year),
        .dow        (dow),
        .new_month  (new_month),
        .new_year   (new_year),
        .day_1s     (day_1s),
        .day_10s    (day_10s),
        .month_1s   (month_1s),
        .month_10s  (month_10s),
        .year_1s    (year_1s),
        .year_10s   (year_10s),
        .year_100s  (year_100s),
        .year_1000s (year_1000s),
        .bcd_valid  (bcd_valid),
        .bcd_ovf    (bcd_ovf)
    );

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_dow(input int v);
        return DOW_EN ? v : 0;
    endfunction

    task automatic expect_date(input string tag, input int d, input int m, input int y);
        expect_eq({tag, " day"}, day, d);
        expect_eq({tag, " month"}, month, m);
        expect_eq({tag, " year"}, year, y);
    endtask

    task automatic expect_digits(input string tag, input int d, input int m, input int y);
        expect_eq({tag, " day10"}, day_10s, d / 10);
        expect_eq({tag, " day1"}, day_1s, d % 10);
        expect_eq({tag, " mon10"}, month_10s, m / 10);
        expect_eq({tag, " mon1"}, month_1s, m % 10);
        expect_eq({tag, " yr1000"}, year_1000s, y / 1000);
        expect_eq({tag, " yr100"}, year_100s, (y / 100) % 10);
        expect_eq({tag, " yr10"}, year_10s, (y / 10) % 10);
        expect_eq({tag, " yr1"}, year_1s, y % 10);
    endtask

    // Called at the first negedge after a date change; checks the exact low window.
    task automatic expect_conv(input string tag);
        expect_eq({tag, " valid first"}, bcd_valid, 0);
        repeat (W) @(negedge clk);
        expect_eq({tag, " valid last"}, bcd_valid, 0);
        @(negedge clk);
        expect_eq({tag, " valid rise"}, bcd_valid, 1);
    endtask

    // Entered and left at a negedge; the posedge in between captures the pulse.
    task automatic do_load(input int d, input int m, input int y, input int dw, input bit tk);
        date_in  = {5'(d), 4'(m), 14'(y)};
        dow_in   = 3'(dw);
        load     = 1'b1;
        day_tick = tk;
        @(negedge clk);
        load     = 1'b0;
        day_tick = 1'b0;
    endtask

    task automatic do_tick();
        day_tick = 1'b1;
        @(negedge clk);
        day_tick = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        day_tick = 1'b0;
        load     = 1'b0;
        date_in  = '0;
        dow_in   = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        expect_date("reset", 1, 1, 2000);
        expect_eq("reset dow", dow, exp_dow(6));
        expect_eq("reset load_err", load_err, 0);
        expect_eq("reset new_month", new_month, 0);
        expect_eq("reset new_year", new_year, 0);
        expect_digits("reset", 0, 0, 0);
        expect_conv("reset");
        expect_digits("reset conv", 1, 1, 2000);
        expect_eq("reset ovf", bcd_ovf, 0);

        // century non-leap year
        do_load(28, 2, 1900, 3, 1'b0);
        expect_date("ld 1900", 28, 2, 1900);
        expect_eq("ld 1900 err", load_err, 0);
        do_tick();
        expect_date("tk 1900", 1, 3, 1900);
        expect_eq("tk 1900 new_month", new_month, 1);
        expect_eq("tk 1900 new_year", new_year, 0);
        do_load(29, 2, 1900, 3, 1'b0);
        expect_eq("ld 29/2/1900 err", load_err, 1);
        expect_date("ld 29/2/1900 held", 1, 3, 1900);

        // 400-year leap
        do_load(28, 2, 2000, 1, 1'b0);
        do_tick();
        expect_date("tk 2000", 29, 2, 2000);
        expect_eq("tk 2000 new_month", new_month, 0);

        // year rollover
        do_load(31, 12, 2023, 0, 1'b0);
        expect_eq("ld 2023 dow", dow, exp_dow(0));
        do_tick();
        expect_date("tk 2023", 1, 1, 2024);
        expect_eq("tk 2023 new_month", new_month, 1);
        expect_eq("tk 2023 new_year", new_year, 1);
        expect_eq("tk 2023 dow", dow, exp_dow(1));
        expect_conv("tk 2023");
        expect_eq("tk 2023 new_month drop", new_month, 0);
        expect_eq("tk 2023 new_year drop", new_year, 0);
        expect_digits("tk 2023", 1, 1, 2024);

        // rejected loads leave everything alone
        do_load(31, 4, 2024, 2, 1'b0);
        expect_eq("ld 31/4 err", load_err, 1);
        expect_date("ld 31/4 held", 1, 1, 2024);
        expect_eq("ld 31/4 valid", bcd_valid, 1);
        @(negedge clk);
        expect_eq("ld 31/4 err drop", load_err, 0);
        do_load(5, 13, 2024, 2, 1'b0);
        expect_eq("ld month13 err", load_err, 1);

        // load wins over a simultaneous tick
        do_load(15, 6, 2024, 6, 1'b1);
        expect_date("ld+tk", 15, 6, 2024);
        expect_eq("ld+tk dow", dow, exp_dow(6));
        expect_eq("ld+tk new_month", new_month, 0);
        expect_eq("ld+tk err", load_err, 0);
        expect_conv("ld+tk");
        expect_digits("ld+tk", 15, 6, 2024);

        // five-digit year saturates the display
        do_load(1, 1, 12000, 0, 1'b0);
        expect_eq("ld 12000 ovf", bcd_ovf, 1);
        expect_conv("ld 12000");
        expect_digits("ld 12000", 1, 1, 9999);

        // year wrap to zero
        do_load(31, 12, 16383, 0, 1'b0);
        do_tick();
        expect_date("wrap", 1, 1, 0);
        expect_eq("wrap new_year", new_year, 1);
        expect_eq("wrap ovf", bcd_ovf, 0);
        expect_conv("wrap");
        expect_digits("wrap", 1, 1, 0);

        // restart on a second change mid-conversion
        do_load(10, 3, 2024, 0, 1'b0);
        expect_conv("pre restart");
        do_tick();
        expect_eq("restart t1 day", day, 11);
        repeat (2) @(negedge clk);
        expect_eq("restart mid valid", bcd_valid, 0);
        do_tick();
        expect_eq("restart t2 day", day, 12);
        expect_digits("restart held", 10, 3, 2024);
        expect_conv("restart");
        expect_digits("restart", 12, 3, 2024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
